// File: rtl/nes_flash_rd_ctrl.sv
// rtl/nes_flash_rd_ctrl.sv - read-only NOR flash sequencer with wait states,
// a one-entry last-address cache and post-reset flash reset pulse.
module nes_flash_rd_ctrl #(
  parameter int ACC_CYCLES = 7,
  parameter int REC_CYCLES = 1,
  parameter int RST_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rd_req,
  input  logic [22:0] i_fl_addr,
  input  logic        i_cache_inv,
  output logic [7:0]  o_rd_data,
  output logic        o_rd_valid,
  output logic        o_busy,
  output logic [22:0] o_fl_a,
  output logic        o_fl_ce_n,
  output logic        o_fl_oe_n,
  output logic        o_fl_we_n,
  output logic        o_fl_rst_n,
  input  logic [7:0]  i_fl_dq
);

  typedef enum logic [1:0] {RSTF, IDLE, ACCESS, RECOVER} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [22:0] fl_a_q, fl_a_d;
  logic        ce_oe_n_q, ce_oe_n_d;
  logic        fl_rst_n_q, fl_rst_n_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        busy_q, busy_d;
  logic        c_valid_q, c_valid_d;
  logic [22:0] c_tag_q, c_tag_d;
  logic [7:0]  c_data_q, c_data_d;

  logic cache_hit;
  logic acc_done;

  assign cache_hit = c_valid_q && (c_tag_q == i_fl_addr) && !i_cache_inv;
  assign acc_done  = (state_q == ACCESS) && (cnt_q == 8'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RSTF;
      cnt_q   <= 8'(RST_CYCLES - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RSTF, RECOVER: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      IDLE: begin
        if (i_rd_req && !cache_hit) begin
          state_d = ACCESS;
          cnt_d   = 8'(ACC_CYCLES - 1);
        end
      end
      ACCESS: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (REC_CYCLES > 0) begin
          state_d = RECOVER;
          cnt_d   = 8'(REC_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = RSTF;
    endcase
  end

  // Pin and status levels follow the next state so every output is a flop.
  always_comb begin
    fl_a_d     = fl_a_q;
    ce_oe_n_d  = (state_d != ACCESS);
    fl_rst_n_d = (state_d != RSTF);
    busy_d     = (state_d != IDLE);
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    c_valid_d  = c_valid_q && !i_cache_inv;
    c_tag_d    = c_tag_q;
    c_data_d   = c_data_q;
    if (state_q == IDLE && i_rd_req) begin
      if (cache_hit) begin
        rd_data_d  = c_data_q;
        rd_valid_d = 1'b1;
      end else begin
        fl_a_d = i_fl_addr;
      end
    end
    if (acc_done) begin
      // A fill completing on the same edge as an invalidate still lands.
      rd_data_d  = i_fl_dq;
      rd_valid_d = 1'b1;
      c_valid_d  = 1'b1;
      c_tag_d    = fl_a_q;
      c_data_d   = i_fl_dq;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fl_a_q     <= '0;
      ce_oe_n_q  <= 1'b1;
      fl_rst_n_q <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b1;
      c_valid_q  <= 1'b0;
      c_tag_q    <= '0;
      c_data_q   <= 8'h00;
    end else begin
      fl_a_q     <= fl_a_d;
      ce_oe_n_q  <= ce_oe_n_d;
      fl_rst_n_q <= fl_rst_n_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      c_valid_q  <= c_valid_d;
      c_tag_q    <= c_tag_d;
      c_data_q   <= c_data_d;
    end
  end

  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_busy     = busy_q;
  assign o_fl_a     = fl_a_q;
  assign o_fl_ce_n  = ce_oe_n_q;
  assign o_fl_oe_n  = ce_oe_n_q;
  assign o_fl_we_n  = 1'b1;
  assign o_fl_rst_n = fl_rst_n_q;

endmodule

// File: tb/tb_nes_flash_rd_ctrl.sv
// tb/tb_nes_flash_rd_ctrl.sv - scoreboard bench for nes_flash_rd_ctrl
// (instance 0: defaults; instance 1: ACC=3, REC=0, RST=4).
module tb_nes_flash_rd_ctrl;

  typedef struct {
    int          idx;
    logic [7:0]  data;
    logic        hit;
    logic [22:0] a;
    longint      cyc;
  } exp_t;

  logic        clk;
  logic        rst      [2];
  logic        rd_req   [2];
  logic [22:0] addr     [2];
  logic        inv      [2];
  logic [7:0]  rd_data  [2];
  logic        rd_valid [2];
  logic        busy     [2];
  logic [22:0] fl_a     [2];
  logic        ce_n     [2];
  logic        oe_n     [2];
  logic        we_n     [2];
  logic        rst_n    [2];
  logic [7:0]  dq       [2];

  logic        force_en;
  logic [7:0]  force_val;
  longint      cyc;
  int          n_tests, n_fail;
  exp_t        exp_q[$];

  logic        mvalid [2];
  logic [22:0] mtag   [2];
  logic [7:0]  mdata  [2];
  int          low_cnt [2];
  logic [22:0] last_a  [2];
  logic [22:0] pool    [6];

  function automatic logic [7:0] fbyte(input logic [22:0] a, input logic fe, input logic [7:0] fv);
    return fe ? fv : (a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h5A);
  endfunction

  function automatic int acc_of(input int idx); return (idx == 0) ? 7 : 3; endfunction
  function automatic int rec_of(input int idx); return (idx == 0) ? 1 : 0; endfunction
  function automatic int rst_of(input int idx); return (idx == 0) ? 16 : 4; endfunction

  assign dq[0] = (!ce_n[0] && !oe_n[0]) ? fbyte(fl_a[0], force_en, force_val) : 8'hEE;
  assign dq[1] = (!ce_n[1] && !oe_n[1]) ? fbyte(fl_a[1], force_en, force_val) : 8'hEE;

  nes_flash_rd_ctrl u_dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_rd_req(rd_req[0]), .i_fl_addr(addr[0]),
    .i_cache_inv(inv[0]), .o_rd_data(rd_data[0]), .o_rd_valid(rd_valid[0]),
    .o_busy(busy[0]), .o_fl_a(fl_a[0]), .o_fl_ce_n(ce_n[0]), .o_fl_oe_n(oe_n[0]),
    .o_fl_we_n(we_n[0]), .o_fl_rst_n(rst_n[0]), .i_fl_dq(dq[0])
  );

  nes_flash_rd_ctrl #(.ACC_CYCLES(3), .REC_CYCLES(0), .RST_CYCLES(4)) u_dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_rd_req(rd_req[1]), .i_fl_addr(addr[1]),
    .i_cache_inv(inv[1]), .o_rd_data(rd_data[1]), .o_rd_valid(rd_valid[1]),
    .o_busy(busy[1]), .o_fl_a(fl_a[1]), .o_fl_ce_n(ce_n[1]), .o_fl_oe_n(oe_n[1]),
    .o_fl_we_n(we_n[1]), .o_fl_rst_n(rst_n[1]), .i_fl_dq(dq[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every read-valid and checks pin activity.
  task automatic mon(input int idx);
    exp_t e;
    if (rst[idx]) begin
      low_cnt[idx] = 0;
    end else begin
      if (!ce_n[idx]) begin
        low_cnt[idx]++;
        last_a[idx] = fl_a[idx];
      end
      if (we_n[idx] !== 1'b1 || ce_n[idx] !== oe_n[idx])
        chk("pin_rules", {we_n[idx], ce_n[idx], oe_n[idx]}, {1'b1, ce_n[idx], ce_n[idx]});
      if (rd_valid[idx]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("valid_instance", idx, e.idx);
          chk("rd_data", rd_data[idx], e.data);
          chk("valid_cycle", cyc, e.cyc);
          chk("busy_after_valid", busy[idx], (!e.hit && rec_of(idx) > 0) ? 1 : 0);
          if (e.hit) begin
            chk("hit_ce_low_cycles", low_cnt[idx], 0);
          end else begin
            chk("miss_ce_low_cycles", low_cnt[idx], acc_of(idx));
            chk("miss_fl_a", last_a[idx], e.a);
          end
        end
        low_cnt[idx] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic wait_idle(input int idx);
    int n = 0;
    while (busy[idx] && n < 1000) begin
      step();
      n++;
    end
    if (n >= 1000) chk("idle_timeout", busy[idx], 0);
  endtask

  task automatic do_reset(input int idx);
    int n = 0;
    int bad_busy = 0;
    rst[idx] = 1'b1;
    step();
    rst[idx] = 1'b0;
    mvalid[idx] = 1'b0;
    while (rst_n[idx] == 1'b0 && n < 300) begin
      if (!busy[idx]) bad_busy++;
      n++;
      step();
    end
    chk("rst_n_low_cycles", n, rst_of(idx));
    chk("busy_during_rstf", bad_busy, 0);
    chk("idle_busy", busy[idx], 0);
    chk("idle_ce_oe_we", {ce_n[idx], oe_n[idx], we_n[idx]}, 3'b111);
    chk("idle_rd_valid", rd_valid[idx], 0);
    chk("idle_rd_data", rd_data[idx], 0);
  endtask

  task automatic issue(input int idx, input logic [22:0] a, input logic iv);
    exp_t e;
    logic hit;
    wait_idle(idx);
    hit = mvalid[idx] && (mtag[idx] == a) && !iv;
    e.idx  = idx;
    e.hit  = hit;
    e.a    = a;
    e.data = hit ? mdata[idx] : fbyte(a, force_en, force_val);
    e.cyc  = cyc + 1 + (hit ? 0 : acc_of(idx));
    exp_q.push_back(e);
    rd_req[idx] = 1'b1;
    addr[idx]   = a;
    inv[idx]    = iv;
    step();
    rd_req[idx] = 1'b0;
    inv[idx]    = 1'b0;
    addr[idx]   = 23'h0;
    if (!hit) begin
      mvalid[idx] = 1'b1;
      mtag[idx]   = a;
      mdata[idx]  = e.data;
    end
  endtask

  task automatic inv_pulse(input int idx);
    wait_idle(idx);
    inv[idx] = 1'b1;
    step();
    inv[idx] = 1'b0;
    mvalid[idx] = 1'b0;
  endtask

  task automatic random_ops(input int idx, input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) == 0) inv_pulse(idx);
      else issue(idx, pool[$urandom_range(0, 5)], ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    force_en  = 1'b0;
    force_val = 8'h00;
    pool[0] = 23'h012345; pool[1] = 23'h012346; pool[2] = 23'h7FFFFF;
    pool[3] = 23'h000000; pool[4] = 23'h2AAAAA; pool[5] = 23'h100000;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; rd_req[i] = 1'b0; addr[i] = '0; inv[i] = 1'b0;
      mvalid[i] = 1'b0; mtag[i] = '0; mdata[i] = '0;
      low_cnt[i] = 0; last_a[i] = '0;
    end
    repeat (2) step();

    do_reset(0);

    force_en  = 1'b1;
    force_val = 8'hA5;
    issue(0, 23'h012345, 1'b0);
    wait_idle(0);
    force_val = 8'h00;
    issue(0, 23'h012345, 1'b0);
    issue(0, 23'h012346, 1'b0);
    issue(0, 23'h012345, 1'b0);
    inv_pulse(0);
    issue(0, 23'h012345, 1'b0);
    issue(0, 23'h012345, 1'b1);
    issue(0, 23'h012345, 1'b0);
    force_en = 1'b0;

    issue(0, 23'h000100, 1'b0);
    step();
    rd_req[0] = 1'b1;
    addr[0]   = 23'h000200;
    step();
    rd_req[0] = 1'b0;
    addr[0]   = 23'h0;

    // Invalidate on the completion edge: the fill must survive.
    issue(0, 23'h3ABCDE, 1'b0);
    repeat (acc_of(0) - 1) step();
    inv[0] = 1'b1;
    step();
    inv[0] = 1'b0;
    issue(0, 23'h3ABCDE, 1'b0);

    issue(0, 23'h7FFFFF, 1'b0);
    issue(0, 23'h000000, 1'b0);
    issue(0, 23'h7FFFFF, 1'b0);

    random_ops(0, 40);

    issue(0, 23'h055555, 1'b0);
    repeat (3) step();
    rst[0] = 1'b1;
    void'(exp_q.pop_back());
    step();
    chk("abort_ce_oe", {ce_n[0], oe_n[0]}, 2'b11);
    chk("abort_rst_n", rst_n[0], 0);
    chk("abort_busy", busy[0], 1);
    rst[0] = 1'b0;
    mvalid[0] = 1'b0;
    wait_idle(0);
    issue(0, 23'h055555, 1'b0);
    issue(0, 23'h055555, 1'b0);

    wait_idle(0);
    repeat (4) step();

    do_reset(1);
    issue(1, 23'h000010, 1'b0);
    issue(1, 23'h000020, 1'b0);
    issue(1, 23'h000030, 1'b0);
    issue(1, 23'h000030, 1'b0);
    random_ops(1, 40);

    for (int n = 0; n < 50 && exp_q.size() > 0; n++) step();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
